// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile
//   I2C slave endpoint with an internal byte register file. Everything runs
//   in the system clock domain: SCL/SDA are synchronised and edge-detected,
//   and START/STOP are recognised as events. Supported transfers are pointer
//   writes, auto-incrementing data writes, and auto-incrementing reads, with
//   repeated START. Clock stretching is not supported.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   scl_in, sda_in  bus pins (raw, asynchronous)
//   sda_oe          1 = pull SDA low (open-drain; pad lives outside)
//   host_addr       side-port read index; host_rdata = reg[host_addr] (comb)
//   wr_stb          one-clk pulse per bus-written byte, with wr_addr/wr_data
//   busy            addressed transaction in progress
//   stop_det        one-clk pulse on any bus STOP
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h33,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PTR_W       = (NUM_REGS <= 2) ? 1 : $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rdata,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy,
  output logic             stop_det
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_WAIT
  } state_t;

  // Synchronisers reset to 1 (idle bus) so a reset never fabricates a START.
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl, sda;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl;
      sda_d    <= sda;
    end
  end

  assign scl = scl_sync[SYNC_STAGES-1];
  assign sda = sda_sync[SYNC_STAGES-1];

  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start_ev = scl & scl_d & sda_d & ~sda;
  assign stop_ev  = scl & scl_d & ~sda_d & sda;

  // Control / datapath state
  state_t           state, state_n;
  logic [2:0]       bit_cnt, bit_n;
  logic [1:0]       ph, ph_n;     // sub-phase inside ACK states
  logic [7:0]       shreg, sh_n;
  logic [PTR_W-1:0] ptr, ptr_n;
  logic             oe_n, busy_n, stb_n, stop_n;
  logic [PTR_W-1:0] waddr_n;
  logic [7:0]       wdata_n;
  logic [7:0]       regs [NUM_REGS];

  logic [7:0]       byte_in, rd_byte;
  logic [PTR_W-1:0] ptr_inc;
  logic             load_rd;

  assign byte_in = {shreg[6:0], sda};
  assign rd_byte = regs[ptr];
  assign ptr_inc = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + PTR_W'(1);

  assign host_rdata = ({1'b0, host_addr} < (PTR_W+1)'(NUM_REGS)) ? regs[host_addr] : 8'h00;

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    ph_n    = ph;
    sh_n    = shreg;
    ptr_n   = ptr;
    oe_n    = sda_oe;
    busy_n  = busy;
    stb_n   = 1'b0;
    waddr_n = wr_addr;
    wdata_n = wr_data;
    stop_n  = 1'b0;
    load_rd = 1'b0;

    if (stop_ev) begin
      state_n = S_IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
      stop_n  = 1'b1;
      ph_n    = '0;
    end else if (start_ev) begin
      state_n = S_ADDR;
      bit_n   = '0;
      oe_n    = 1'b0;
      ph_n    = '0;
    end else begin
      case (state)
        S_ADDR: if (scl_rise) begin
          sh_n  = byte_in;
          bit_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (byte_in[7:1] == SLAVE_ADDR) begin
              state_n = S_ADDR_ACK;
              busy_n  = 1'b1;
            end else begin
              state_n = S_WAIT;
              busy_n  = 1'b0;
            end
          end
        end

        // Fall ending bit 8 pulls SDA low, fall ending bit 9 releases it.
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
          if (ph == 2'd0) begin
            oe_n = 1'b1;
            ph_n = 2'd1;
          end else begin
            oe_n  = 1'b0;
            ph_n  = 2'd0;
            bit_n = '0;
            if (state == S_ADDR_ACK && shreg[0]) load_rd = 1'b1;
            else if (state == S_ADDR_ACK)        state_n = S_PTR;
            else                                 state_n = S_WDATA;
          end
        end

        S_PTR: if (scl_rise) begin
          sh_n  = byte_in;
          bit_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if ({1'b0, byte_in} < 9'(NUM_REGS)) begin
              ptr_n   = byte_in[PTR_W-1:0];
              state_n = S_PTR_ACK;
            end else begin
              state_n = S_WAIT;
            end
          end
        end

        S_WDATA: if (scl_rise) begin
          sh_n  = byte_in;
          bit_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            stb_n   = 1'b1;
            waddr_n = ptr;
            wdata_n = byte_in;
            ptr_n   = ptr_inc;
            state_n = S_WDATA_ACK;
          end
        end

        // MSB is already on the bus at entry; each later fall shifts out the next bit.
        S_RDATA: begin
          if (scl_rise) begin
            bit_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr_n   = ptr_inc;
              state_n = S_RACK;
              ph_n    = 2'd0;
            end
          end else if (scl_fall && bit_cnt != 3'd0) begin
            sh_n = {shreg[6:0], 1'b0};
            oe_n = ~shreg[6];
          end
        end

        // ph 0: release on fall ending bit 8; ph 1: sample master bit;
        // ph 2: master ACKed, present next byte on the fall ending bit 9.
        S_RACK: begin
          if (ph == 2'd0 && scl_fall) begin
            oe_n = 1'b0;
            ph_n = 2'd1;
          end else if (ph == 2'd1 && scl_rise) begin
            if (sda) begin
              state_n = S_WAIT;
              ph_n    = 2'd0;
            end else begin
              ph_n = 2'd2;
            end
          end else if (ph == 2'd2 && scl_fall) begin
            load_rd = 1'b1;
          end
        end

        default: ;  // S_IDLE, S_WAIT: only START/STOP matter
      endcase
    end

    if (load_rd) begin
      state_n = S_RDATA;
      sh_n    = rd_byte;
      oe_n    = ~rd_byte[7];
      bit_n   = '0;
      ph_n    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      ph       <= '0;
      shreg    <= '0;
      ptr      <= '0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_stb   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      stop_det <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_n;
      ph       <= ph_n;
      shreg    <= sh_n;
      ptr      <= ptr_n;
      sda_oe   <= oe_n;
      busy     <= busy_n;
      wr_stb   <= stb_n;
      wr_addr  <= waddr_n;
      wr_data  <= wdata_n;
      stop_det <= stop_n;
      if (stb_n) regs[ptr] <= wdata_n;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: an I2C master model drives SCL/SDA
// (open-drain bus resolved with the DUT's sda_oe), a table of write
// transactions is applied in a loop, and hand-written sequences cover
// combined read with wrap, abort by repeated START, ACK drive latency and
// reset during an ACK. A register model tracks expected contents.
module tb_i2c_slave_regfile;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [3:0] host_addr = '0;
  logic [7:0] host_rdata;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       stop_det;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h33), .NUM_REGS(16), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .host_addr(host_addr), .host_rdata(host_rdata), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .stop_det(stop_det)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Monitors, sampled on the falling clock edge
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int          stop_cnt = 0;
  logic        busy_seen = 1'b0;
  logic        oe_seen   = 1'b0;

  always @(negedge clk) begin
    if (wr_stb)   got_q.push_back({4'h0, wr_addr, wr_data});
    if (stop_det) stop_cnt++;
    if (busy)     busy_seen = 1'b1;
    if (sda_oe)   oe_seen   = 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- master model ----------------
  task automatic q();
    repeat (10) @(negedge clk);
  endtask

  // Data up, SCL high, sample mid-high, SCL low (ends on the SCL fall).
  task automatic bit_hi(input logic b, output logic r);
    sda_m = b; q(); scl = 1'b1; q(); r = sda_bus; q(); scl = 1'b0;
  endtask

  task automatic wbit(input logic b, output logic r);
    bit_hi(b, r); q();
  endtask

  task automatic start_c();
    sda_m = 1'b1; q(); scl = 1'b1; q(); sda_m = 1'b0; q(); scl = 1'b0; q();
  endtask

  task automatic stop_c();
    sda_m = 1'b0; q(); scl = 1'b1; q(); sda_m = 1'b1; q();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) wbit(d[i], r);
    wbit(1'b1, r);
    ack = ~r;
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      wbit(1'b1, r);
      d = {d[6:0], r};
    end
    wbit(nack, r);
  endtask

  task automatic chk_stb(input string nm);
    chk({nm, "_stb_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({nm, "_stb_addr_data"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- register model ----------------
  logic [7:0] model [16];
  logic [3:0] mptr;

  task automatic chk_regs(input string nm);
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i);
      #1;
      chk($sformatf("%s_reg%0d", nm, i), 32'(host_rdata), 32'(model[i]));
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] ptr;
    int         nd;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       aack;   // address byte expected to be ACKed
    logic       pack;   // pointer byte expected to be ACKed
  } wvec_t;

  wvec_t vec [5];

  initial begin
    logic       a;
    logic [7:0] d, dd;
    int         sc0;

    vec[0] = '{8'h66, 8'h03, 2, 8'hA5, 8'h5A, 1'b1, 1'b1};  // basic two-byte write
    vec[1] = '{8'h66, 8'h0F, 2, 8'h11, 8'h22, 1'b1, 1'b1};  // write wraps 15 -> 0
    vec[2] = '{8'h68, 8'hFF, 0, 8'h00, 8'h00, 1'b0, 1'b0};  // address mismatch
    vec[3] = '{8'h66, 8'h10, 1, 8'h77, 8'h00, 1'b1, 1'b0};  // pointer out of range
    vec[4] = '{8'h66, 8'h07, 1, 8'hC3, 8'h00, 1'b1, 1'b1};  // single byte

    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    mptr = '0;

    // ---- reset state ----
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_wr_stb", 32'(wr_stb), 0);
    chk("rst_stop_det", 32'(stop_det), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk_regs("rst");

    // ---- table-driven write transactions ----
    for (int v = 0; v < 5; v++) begin
      busy_seen = 1'b0;
      oe_seen   = 1'b0;
      sc0       = stop_cnt;
      start_c();
      wbyte(vec[v].addr, a);
      chk($sformatf("v%0d_addr_ack", v), 32'(a), 32'(vec[v].aack));
      wbyte(vec[v].ptr, a);
      chk($sformatf("v%0d_ptr_ack", v), 32'(a), 32'(vec[v].aack & vec[v].pack));
      if (vec[v].aack && vec[v].pack) mptr = vec[v].ptr[3:0];
      for (int j = 0; j < vec[v].nd; j++) begin
        d = (j == 0) ? vec[v].d0 : vec[v].d1;
        wbyte(d, a);
        chk($sformatf("v%0d_data_ack%0d", v, j), 32'(a), 32'(vec[v].aack & vec[v].pack));
        if (vec[v].aack && vec[v].pack) begin
          exp_q.push_back({4'h0, mptr, d});
          model[mptr] = d;
          mptr = mptr + 4'd1;
        end
      end
      stop_c();
      q();
      chk_stb($sformatf("v%0d", v));
      chk($sformatf("v%0d_stop_pulses", v), 32'(stop_cnt - sc0), 1);
      chk($sformatf("v%0d_busy_after_stop", v), 32'(busy), 0);
      chk($sformatf("v%0d_busy_seen", v), 32'(busy_seen), 32'(vec[v].aack));
      chk($sformatf("v%0d_oe_seen", v), 32'(oe_seen), 32'(vec[v].aack));
    end
    chk_regs("after_writes");

    // ---- combined read with repeated START, wraps 15 -> 0 ----
    start_c();
    wbyte(8'h66, a); chk("rd_addr_w_ack", 32'(a), 1);
    wbyte(8'h0F, a); chk("rd_ptr_ack", 32'(a), 1);
    mptr = 4'hF;
    start_c();
    wbyte(8'h67, a); chk("rd_addr_r_ack", 32'(a), 1);
    rbyte(1'b0, d);  chk("rd_byte0", 32'(d), 32'(model[mptr]));
    mptr = mptr + 4'd1;
    rbyte(1'b1, dd); chk("rd_byte1_wrap", 32'(dd), 32'(model[mptr]));
    mptr = mptr + 4'd1;
    chk("rd_oe_after_nack", 32'(sda_oe), 0);
    chk("rd_busy_before_stop", 32'(busy), 1);
    stop_c();
    q();
    chk_stb("rd");

    // ---- abort: repeated START after 4 bits of a data byte ----
    start_c();
    wbyte(8'h66, a); chk("ab_addr_ack", 32'(a), 1);
    wbyte(8'h03, a); chk("ab_ptr_ack", 32'(a), 1);
    mptr = 4'h3;
    wbit(1'b0, a); wbit(1'b1, a); wbit(1'b1, a); wbit(1'b0, a);
    start_c();
    wbyte(8'h67, a); chk("ab_readdr_ack", 32'(a), 1);
    rbyte(1'b1, d);  chk("ab_ptr_unchanged", 32'(d), 32'(model[mptr]));
    mptr = mptr + 4'd1;
    stop_c();
    q();
    chk_stb("ab");
    chk_regs("after_abort");

    // ---- ACK drive latency, then reset while ACK is driven ----
    start_c();
    for (int i = 7; i >= 1; i--) wbit(1'(8'h66 >> i), a);
    bit_hi(1'b0, a);                 // bit 8; SCL pin falls here
    @(negedge clk); @(negedge clk);
    chk("ack_lat_early", 32'(sda_oe), 0);
    @(negedge clk);
    chk("ack_lat_ss_plus_1", 32'(sda_oe), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack_oe", 32'(sda_oe), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 0);
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    chk_regs("rst_mid");
    got_q.delete();

    start_c();
    wbyte(8'h66, a); chk("post_rst_addr_ack", 32'(a), 1);
    wbyte(8'h02, a); chk("post_rst_ptr_ack", 32'(a), 1);
    wbyte(8'h9C, a); chk("post_rst_data_ack", 32'(a), 1);
    exp_q.push_back({4'h0, 4'h2, 8'h9C});
    model[2] = 8'h9C;
    stop_c();
    q();
    chk_stb("post_rst");
    chk_regs("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
